// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. A horizontal counter runs over
//   the full line (active + porches + sync) and the vertical counter steps
//   once per line wrap. Syncs, blank and strobes are registered and decoded
//   from the next-state counters, so every output describes the same pixel
//   position as pix_x/pix_y in the same cycle (no skew between them).
//
//   Optional build macro: VGA_PIXEL_DIV_EN
//     defined   : an internal toggle flop halves the advance rate, so the
//                 counters step every second enabled clock (25 MHz pixel
//                 timing from a 50 MHz clock).
//     undefined : the counters step on every enabled clock.
//
// Ports
//   clock        in   system clock
//   reset        in   asynchronous, active-low reset
//   enable       in   advance timing when high
//   hsync        out  horizontal sync, active level HS_POL
//   vsync        out  vertical sync, active level VS_POL
//   blank        out  1 = visible area, 0 = blanking (BLANK_N style)
//   pix_x        out  current horizontal position (0..H_TOTAL-1)
//   pix_y        out  current vertical position (0..V_TOTAL-1)
//   line_start   out  one-cycle pulse when the position becomes h=0
//   frame_start  out  one-cycle pulse when the position becomes (0,0)
//   frame_count  out  frames completed, wraps 255->0
//   pixel_tick   out  high on cycles where the counters advance
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count,
  output logic             pixel_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_field
      $error("vga_timing_gen: every timing field must be at least 1");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
      $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
  endgenerate

  // Inclusive window test used for both sync decodes.
  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  logic             vld_p0;
  logic [CNT_W-1:0] h_nxt_p0;
  logic [CNT_W-1:0] v_nxt_p0;
  logic             wrap_p0;
  logic [CNT_W-1:0] hcnt_p1;
  logic [CNT_W-1:0] vcnt_p1;

  // ---- p0: advance qualifier and next-state counters ----
`ifdef VGA_PIXEL_DIV_EN
  logic div_tgl;

  // Toggle only moves on enabled clocks, so a paused raster resumes with
  // the same phase relation between clock and pixel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_tgl <= 1'b0;
    end else if (enable) begin
      div_tgl <= ~div_tgl;
    end
  end

  assign vld_p0 = enable & div_tgl;
`else
  assign vld_p0 = enable;
`endif

  assign pixel_tick = vld_p0;

  always_comb begin
    h_nxt_p0 = hcnt_p1;
    v_nxt_p0 = vcnt_p1;
    if (vld_p0) begin
      if (hcnt_p1 == H_LAST) begin
        h_nxt_p0 = '0;
        v_nxt_p0 = (vcnt_p1 == V_LAST) ? '0 : vcnt_p1 + 1'b1;
      end else begin
        h_nxt_p0 = hcnt_p1 + 1'b1;
      end
    end
  end

  // A new position of h=0 can only come from an advancing wrap; hold
  // cycles at h=0 must not re-fire the strobes.
  assign wrap_p0 = vld_p0 && (h_nxt_p0 == '0);

  // ---- p1: registered position and decoded outputs ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcnt_p1     <= '0;
      vcnt_p1     <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      hcnt_p1     <= h_nxt_p0;
      vcnt_p1     <= v_nxt_p0;
      hsync       <= in_window(h_nxt_p0, HS_BEG, HS_END) ? HS_POL : ~HS_POL;
      vsync       <= in_window(v_nxt_p0, VS_BEG, VS_END) ? VS_POL : ~VS_POL;
      blank       <= (h_nxt_p0 < H_ACT) && (v_nxt_p0 < V_ACT);
      line_start  <= wrap_p0;
      frame_start <= wrap_p0 && (v_nxt_p0 == '0);
      if (wrap_p0 && (v_nxt_p0 == '0)) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign pix_x = hcnt_p1;
  assign pix_y = vcnt_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. One instance uses the default
//   640x480 timing, a second uses a tiny 8x6 raster with active-high syncs
//   so that whole frames and the (last,last)->(0,0) wrap fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default-parameter instance
  logic       rn_d, en_d;
  logic       d_hs, d_vs, d_bl, d_ls, d_fs, d_pt;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;

  // Small-raster instance: H=4/1/2/1, V=3/1/1/1, active-high syncs
  logic       rn_s, en_s;
  logic       s_hs, s_vs, s_bl, s_ls, s_fs, s_pt;
  logic [3:0] s_x, s_y;
  logic [7:0] s_fc;

  vga_timing_gen u_dut_d (
    .clock       (clk),
    .reset       (rn_d),
    .enable      (en_d),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .blank       (d_bl),
    .pix_x       (d_x),
    .pix_y       (d_y),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_count (d_fc),
    .pixel_tick  (d_pt)
  );

  vga_timing_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1'b1), .VS_POL (1'b1), .CNT_W (4)
  ) u_dut_s (
    .clock       (clk),
    .reset       (rn_s),
    .enable      (en_s),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .blank       (s_bl),
    .pix_x       (s_x),
    .pix_y       (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_count (s_fc),
    .pixel_tick  (s_pt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_low, ls_cnt, ls_at, h, v, fc;
    int fs_cnt, fs_first, fs_second, vs_cnt, bl_cnt;

    rn_d = 1'b0; en_d = 1'b0;
    rn_s = 1'b0; en_s = 1'b0;
    #12;

    // Reset state of the default instance
    check("rst_pix_x", d_x, 0);
    check("rst_pix_y", d_y, 0);
    check("rst_blank", d_bl, 1);
    check("rst_hsync", d_hs, 1);
    check("rst_vsync", d_vs, 1);
    check("rst_line_start", d_ls, 0);
    check("rst_frame_start", d_fs, 0);
    check("rst_frame_count", d_fc, 0);

    // Release: (0,0) is presented without strobes until the first edge
    rn_d = 1'b1; en_d = 1'b1;
    #1;
    check("rel_pix_x", d_x, 0);
    check("rel_line_start", d_ls, 0);
    check("rel_pixel_tick", d_pt, 1);

    // One full line plus the wrap into line 1
    hs_low = 0; ls_cnt = 0; ls_at = -1;
    for (int k = 1; k <= 800; k++) begin
      step();
      h = k % 800;
      v = k / 800;
      check("line_pix_x", d_x, h);
      check("line_pix_y", d_y, v);
      check("line_hsync", d_hs, (h >= 656 && h <= 751) ? 0 : 1);
      check("line_blank", d_bl, (h < 640) ? 1 : 0);
      check("line_start_k", d_ls, (h == 0) ? 1 : 0);
      check("line_frame_start", d_fs, 0);
      if (d_hs === 1'b0) hs_low++;
      if (d_ls === 1'b1) begin
        ls_cnt++;
        ls_at = k;
      end
    end
    check("hsync_low_cycles", hs_low, 96);
    check("line_start_count", ls_cnt, 1);
    check("line_start_cycle", ls_at, 800);
    check("line_vsync", d_vs, 1);
    check("line_frame_count", d_fc, 0);

    // Run to h=100 on line 1, then hold for 50 cycles
    for (int k = 0; k < 100; k++) step();
    check("pre_hold_pix_x", d_x, 100);
    en_d = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      check("hold_pix_x", d_x, 100);
      check("hold_pix_y", d_y, 1);
      check("hold_line_start", d_ls, 0);
      check("hold_pixel_tick", d_pt, 0);
      check("hold_blank", d_bl, 1);
    end
    en_d = 1'b1;
    step();
    check("resume_pix_x", d_x, 101);
    check("resume_pix_y", d_y, 1);

    // Asynchronous reset between edges at (300,1)
    for (int k = 0; k < 199; k++) step();
    check("pre_rst_pix_x", d_x, 300);
    #3;
    rn_d = 1'b0;
    #1;
    check("async_pix_x", d_x, 0);
    check("async_pix_y", d_y, 0);
    check("async_blank", d_bl, 1);
    check("async_hsync", d_hs, 1);
    check("async_vsync", d_vs, 1);
    check("async_line_start", d_ls, 0);
    check("async_frame_start", d_fs, 0);
    check("async_frame_count", d_fc, 0);
    #2;
    rn_d = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("post_rst_pix_x", d_x, k);
      check("post_rst_frame_start", d_fs, 0);
      check("post_rst_line_start", d_ls, 0);
    end

    // Small raster: 8 clocks per line, 6 lines, 48 clocks per frame
    rn_s = 1'b1; en_s = 1'b1;
    #1;
    check("s_rel_pix_x", s_x, 0);
    check("s_rel_frame_start", s_fs, 0);
    check("s_rel_hsync", s_hs, 0);
    check("s_rel_vsync", s_vs, 0);
    fs_cnt = 0; fs_first = -1; fs_second = -1; vs_cnt = 0; bl_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      h  = k % 8;
      v  = (k / 8) % 6;
      fc = k / 48;
      check("s_pix_x", s_x, h);
      check("s_pix_y", s_y, v);
      check("s_hsync", s_hs, (h >= 5 && h <= 6) ? 1 : 0);
      check("s_vsync", s_vs, (v == 4) ? 1 : 0);
      check("s_blank", s_bl, (h < 4 && v < 3) ? 1 : 0);
      check("s_line_start", s_ls, (h == 0) ? 1 : 0);
      check("s_frame_start", s_fs, (h == 0 && v == 0) ? 1 : 0);
      check("s_frame_count", s_fc, fc);
      check("s_pixel_tick", s_pt, 1);
      if (k <= 48 && s_vs === 1'b1) vs_cnt++;
      if (k <= 48 && s_bl === 1'b1) bl_cnt++;
      if (s_fs === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (k == 20) check("s_edge_3_2_blank", s_bl, 0);
      if (k == 19) check("s_edge_3_2_pre_blank", s_bl, 1);
    end
    check("s_frame_start_count", fs_cnt, 2);
    check("s_first_frame_start", fs_first, 48);
    check("s_frame_period", fs_second - fs_first, 48);
    check("s_vsync_cycles", vs_cnt, 8);
    check("s_blank_cycles", bl_cnt, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on total run time in case the main sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
